// File: rtl/mem64_pkg.sv
// Shared types, sizes and contents for the 64x5 VGA lookup ROM.
package mem64_pkg;

  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned DATA_WIDTH = 5;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Word a holds (7*a + 3) mod 32. 7*32 is 0 mod 32, so the upper half repeats the lower half.
  localparam data_t ROM_INIT [0:DEPTH-1] = '{
    5'd3,  5'd10, 5'd17, 5'd24, 5'd31, 5'd6,  5'd13, 5'd20,
    5'd27, 5'd2,  5'd9,  5'd16, 5'd23, 5'd30, 5'd5,  5'd12,
    5'd19, 5'd26, 5'd1,  5'd8,  5'd15, 5'd22, 5'd29, 5'd4,
    5'd11, 5'd18, 5'd25, 5'd0,  5'd7,  5'd14, 5'd21, 5'd28,
    5'd3,  5'd10, 5'd17, 5'd24, 5'd31, 5'd6,  5'd13, 5'd20,
    5'd27, 5'd2,  5'd9,  5'd16, 5'd23, 5'd30, 5'd5,  5'd12,
    5'd19, 5'd26, 5'd1,  5'd8,  5'd15, 5'd22, 5'd29, 5'd4,
    5'd11, 5'd18, 5'd25, 5'd0,  5'd7,  5'd14, 5'd21, 5'd28
  };

  // Closed-form value of a ROM word.
  function automatic data_t rom_value(addr_t a);
    int unsigned full;
    full = (7 * int'(a) + 3) % 32;
    return data_t'(full);
  endfunction

endpackage

// File: rtl/mem64_rom_if.sv
// Read bus of the lookup ROM: address in, registered data out.
interface mem64_rom_if;
  import mem64_pkg::*;

  addr_t rAddr;
  data_t dataOut;

  modport master (output rAddr, input dataOut);
  modport slave  (input rAddr, output dataOut);

endinterface

// File: rtl/mem64_rom.sv
// 64-word by 5-bit synchronous-read ROM with a registered output.
module mem64_rom
  import mem64_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  mem64_rom_if.slave  bus
);

  data_t dataD;
  data_t dataQ;

  // Table lookup; only feeds the output register, never the port directly.
  always_comb begin
    dataD = ROM_INIT[bus.rAddr];
  end

  // Output register; reset wins over the read.
  always_ff @(posedge clock) begin
    if (reset) begin
      dataQ <= '0;
    end else begin
      dataQ <= dataD;
    end
  end

  assign bus.dataOut = dataQ;

endmodule

// File: tb/tb_mem64_rom.sv
// Directed bench for the 64x5 lookup ROM.
module tb_mem64_rom;
  import mem64_pkg::*;

  logic clock;
  logic reset;
  int   nVectors;
  int   nMiscompares;

  mem64_rom_if bus ();

  mem64_rom dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input data_t got, input data_t exp);
    nVectors++;
    if (got !== exp) begin
      nMiscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hand-computed spot values: {addr, expected}.
  localparam int NSPOT = 8;
  int spotAddr [NSPOT] = '{0, 1, 2, 4, 5, 31, 32, 63};
  int spotData [NSPOT] = '{3, 10, 17, 31, 6, 28, 3, 28};

  initial begin
    addr_t prevAddr;
    nVectors     = 0;
    nMiscompares = 0;

    // Reset held for three edges at address 5, then release.
    reset     = 1'b1;
    bus.rAddr = addr_t'(5);
    for (int i = 0; i < 3; i++) begin
      step();
      checkVal("reset_hold", bus.dataOut, 5'd0);
    end
    reset = 1'b0;
    step();
    checkVal("reset_release", bus.dataOut, 5'd6);

    // Hand-computed spot checks.
    for (int i = 0; i < NSPOT; i++) begin
      bus.rAddr = addr_t'(spotAddr[i]);
      step();
      checkVal($sformatf("spot_%0d", spotAddr[i]), bus.dataOut, data_t'(spotData[i]));
    end

    // Sweep, address changing every two cycles.
    for (int a = 0; a < 64; a++) begin
      bus.rAddr = addr_t'(a);
      step();
      checkVal($sformatf("sweep_%0d", a), bus.dataOut, rom_value(addr_t'(a)));
      step();
      checkVal($sformatf("sweep_hold_%0d", a), bus.dataOut, rom_value(addr_t'(a)));
    end

    // Wrap on consecutive edges.
    bus.rAddr = addr_t'(62);
    step();
    checkVal("wrap_62", bus.dataOut, 5'd21);
    bus.rAddr = addr_t'(63);
    step();
    checkVal("wrap_63", bus.dataOut, 5'd28);
    bus.rAddr = bus.rAddr + addr_t'(1);
    step();
    checkVal("wrap_0", bus.dataOut, 5'd3);

    // Back-to-back random addresses.
    for (int i = 0; i < 200; i++) begin
      prevAddr  = addr_t'($urandom_range(63, 0));
      bus.rAddr = prevAddr;
      step();
      checkVal($sformatf("rand_%0d", prevAddr), bus.dataOut, rom_value(prevAddr));
    end

    // Sweep with a one-edge reset pulse at address 20.
    for (int a = 15; a < 26; a++) begin
      bus.rAddr = addr_t'(a);
      if (a == 20) begin
        reset = 1'b1;
        step();
        checkVal("midreset_pulse", bus.dataOut, 5'd0);
        reset = 1'b0;
        step();
        checkVal("midreset_after", bus.dataOut, 5'd15);
      end else begin
        step();
        checkVal($sformatf("midsweep_%0d", a), bus.dataOut, rom_value(addr_t'(a)));
      end
    end

    // Hold address 32; check just after the edge and mid-cycle.
    bus.rAddr = addr_t'(32);
    for (int i = 0; i < 10; i++) begin
      step();
      checkVal("hold_edge", bus.dataOut, 5'd3);
      #4;
      checkVal("hold_mid", bus.dataOut, 5'd3);
    end

    // The output must not follow the address between edges.
    bus.rAddr = addr_t'(4);
    #2;
    checkVal("no_comb_path", bus.dataOut, 5'd3);
    step();
    checkVal("after_comb_edge", bus.dataOut, 5'd31);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
